// File: rtl/calc_mp_if.sv
// calc_mp_if -- requester bus for the multi-port calculator.
//   req_cmd_in  : per-port 4-bit command   (port i at bits i*4 +: 4)
//   req_data_in : per-port operand         (port i at bits i*DATA_W +: DATA_W)
//   out_resp    : per-port response        (0 none, 1 success, 2 error)
//   out_data    : per-port result
//   port_busy   : per-port outstanding-request flag
// Packed 2-D arrays give exactly the flattened bit layout of a 1-D bus.
interface calc_mp_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0][3:0]        req_cmd_in;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_data_in;
    logic [NUM_PORTS-1:0][1:0]        out_resp;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;
    logic [NUM_PORTS-1:0]             port_busy;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, port_busy
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, port_busy
    );
endinterface

// File: rtl/calc_mp.sv
// calc_mp -- NUM_PORTS independent requesters sharing one ALU.
// Each port captures cmd+operand1, then operand2, waits in PEND for a
// round-robin grant, registers its result for one DONE cycle, then idles.
// Ports:
//   c_clk   : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : calc_mp_if slave modport (commands in, responses out)
module calc_mp #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic     c_clk,
    input  logic     reset_n,
    calc_mp_if.slave bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SH_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, OPND2, PEND, DONE} state_e;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    logic [NUM_PORTS-1:0]             pend;
    logic [NUM_PORTS-1:0][3:0]        cmd_all;
    logic [NUM_PORTS-1:0][DATA_W-1:0] op1_all;
    logic [NUM_PORTS-1:0][DATA_W-1:0] op2_all;
    logic [NUM_PORTS-1:0]             gnt_oh;

    // ---------------- round-robin arbiter ----------------
    // ptr_q is the first port searched; it points one past the last grant.
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx, ptr_q, ptr_d, cand;
    logic [IDX_W:0]   sum_idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        sum_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // ptr_q + k < 2*NUM_PORTS, so one conditional subtract wraps it
            sum_idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum_idx >= (IDX_W+1)'(NUM_PORTS))
                sum_idx = sum_idx - (IDX_W+1)'(NUM_PORTS);
            cand = sum_idx[IDX_W-1:0];
            if (!gnt_vld && pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld)
            ptr_d = (gnt_idx == IDX_W'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    // ---------------- shared ALU ----------------
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_a, alu_b, alu_data;
    logic [DATA_W:0]   alu_sum;
    logic [SH_W-1:0]   alu_sh;
    logic [1:0]        alu_resp;

    always_comb begin
        alu_cmd  = cmd_all[gnt_idx];
        alu_a    = op1_all[gnt_idx];
        alu_b    = op2_all[gnt_idx];
        alu_sh   = alu_b[SH_W-1:0];
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_resp = RESP_ERR;   // invalid codes fall through as error
        alu_data = '0;
        case (alu_cmd)
            CMD_ADD: if (!alu_sum[DATA_W]) begin
                alu_resp = RESP_OK;
                alu_data = alu_sum[DATA_W-1:0];
            end
            CMD_SUB: if (alu_b <= alu_a) begin
                alu_resp = RESP_OK;
                alu_data = alu_a - alu_b;
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = alu_a << alu_sh;
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = alu_a >> alu_sh;
            end
            default: ;
        endcase
    end

    // ---------------- per-port FSMs ----------------
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        state_e            state_q;
        logic [3:0]        cmd_q;
        logic [DATA_W-1:0] op1_q, op2_q, data_q;
        logic [1:0]        resp_q;
        logic              busy_q;

        always_ff @(posedge c_clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cmd_q   <= '0;
                op1_q   <= '0;
                op2_q   <= '0;
                resp_q  <= RESP_NONE;
                data_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (bus.req_cmd_in[i] != 4'd0) begin
                        cmd_q   <= bus.req_cmd_in[i];
                        op1_q   <= bus.req_data_in[i];
                        busy_q  <= 1'b1;
                        state_q <= OPND2;
                    end
                    OPND2: begin
                        op2_q   <= bus.req_data_in[i];
                        state_q <= PEND;
                    end
                    PEND: if (gnt_oh[i]) begin
                        resp_q  <= alu_resp;
                        data_q  <= alu_data;
                        state_q <= DONE;
                    end
                    DONE: begin
                        resp_q  <= RESP_NONE;
                        data_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign pend[i]          = (state_q == PEND);
        assign cmd_all[i]       = cmd_q;
        assign op1_all[i]       = op1_q;
        assign op2_all[i]       = op2_q;
        assign bus.out_resp[i]  = resp_q;
        assign bus.out_data[i]  = data_q;
        assign bus.port_busy[i] = busy_q;
    end
endmodule

// File: tb/tb_calc_mp.sv
// tb_calc_mp -- scoreboard bench for calc_mp. Expected responses (port,
// resp, data, cycle) are queued as stimulus is driven; a negedge monitor
// pops and compares every response the DUT produces.
module tb_calc_mp;
    localparam int NP = 4;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_mp_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();
    calc_mp #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .c_clk   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (bus.out_resp[p] != 2'd0) begin
                int idx;
                idx = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (idx < 0 && sb[j].port == p) idx = j;
                if (idx < 0) begin
                    chk($sformatf("unexpected_resp_p%0d", p), 64'(bus.out_resp[p]), 64'd0);
                end else begin
                    chk($sformatf("resp_p%0d", p), 64'(bus.out_resp[p]), 64'(sb[idx].resp));
                    chk($sformatf("data_p%0d", p), 64'(bus.out_data[p]), 64'(sb[idx].data));
                    chk($sformatf("cycle_p%0d", p), 64'(cyc), 64'(sb[idx].cyc));
                    sb.delete(idx);
                end
            end else if (bus.out_data[p] != '0) begin
                chk($sformatf("data_no_resp_p%0d", p), 64'(bus.out_data[p]), 64'd0);
            end
        end
    end

    task automatic push(input int p, input logic [1:0] r, input logic [DW-1:0] d, input int lat);
        exp_t e;
        e.port = p; e.resp = r; e.data = d; e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 60 && !(sb.size() == 0 && bus.port_busy == '0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk("drain_timeout_busy", 64'(bus.port_busy), 64'd0);
            chk("drain_timeout_pending", 64'(sb.size()), 64'd0);
        end
    endtask

    // Single-port transaction; cmd stays asserted through the operand2
    // cycle, where it must be ignored.
    task automatic op(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [1:0] r, input logic [DW-1:0] d);
        @(negedge clk);
        push(p, r, d, 3);
        bus.req_cmd_in[p]  = c;
        bus.req_data_in[p] = a;
        @(negedge clk);
        bus.req_data_in[p] = b;
        @(negedge clk);
        bus.req_cmd_in[p]  = '0;
        bus.req_data_in[p] = '0;
        wait_idle();
    endtask

    // Several ports issue on the same edge; lat gives each grant order slot.
    task automatic burst(input logic [NP-1:0][3:0] c, input logic [NP-1:0][DW-1:0] a,
                         input logic [NP-1:0][DW-1:0] b, input logic [NP-1:0][1:0] r,
                         input logic [NP-1:0][DW-1:0] d, input logic [NP-1:0][3:0] lat);
        @(negedge clk);
        for (int p = 0; p < NP; p++) if (c[p] != 4'd0) push(p, r[p], d[p], int'(lat[p]));
        bus.req_cmd_in  = c;
        bus.req_data_in = a;
        @(negedge clk);
        bus.req_cmd_in  = '0;
        bus.req_data_in = b;
        @(negedge clk);
        bus.req_data_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_resp", 64'(bus.out_resp), 64'd0);
        chk("reset_data", 64'(bus.out_data), 64'd0);
        chk("reset_busy", 64'(bus.port_busy), 64'd0);
        rst_n = 1'b1;

        // Basic add with busy timing: busy rises at T, stays through DONE
        @(negedge clk);
        push(0, 2'd1, 32'h0200_0000, 3);
        bus.req_cmd_in[0] = 4'd1; bus.req_data_in[0] = 32'h1;
        @(negedge clk);
        chk("busy_T", 64'(bus.port_busy[0]), 64'd1);
        bus.req_cmd_in[0] = 4'd0; bus.req_data_in[0] = 32'h01FF_FFFF;
        @(negedge clk);
        chk("busy_T1", 64'(bus.port_busy[0]), 64'd1);
        bus.req_data_in[0] = '0;
        @(negedge clk);
        chk("busy_T2", 64'(bus.port_busy[0]), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(bus.port_busy[0]), 64'd0);
        wait_idle();

        // Arithmetic boundaries and invalid codes
        op(0, 4'd1, 32'hFFFF_FFFF, 32'h1,         2'd2, 32'h0);
        op(0, 4'd2, 32'h1,         32'hF,         2'd2, 32'h0);
        op(0, 4'd2, 32'hF,         32'h1,         2'd1, 32'hE);
        op(0, 4'd2, 32'h5,         32'h5,         2'd1, 32'h0);
        op(0, 4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 32'hFFFF_FFFF);
        op(0, 4'd3, 32'h1,         32'h1,         2'd2, 32'h0);
        op(0, 4'd4, 32'h1,         32'h1,         2'd2, 32'h0);
        op(2, 4'd15, 32'h1,        32'h1,         2'd2, 32'h0);
        op(0, 4'd6, 32'h8000_0001, 32'd33,        2'd1, 32'h4000_0000);
        op(2, 4'd5, 32'h8000_0001, 32'd1,         2'd1, 32'h2);
        op(3, 4'd5, 32'h1,         32'd63,        2'd1, 32'h8000_0000);

        // Commands presented in PEND (grant edge) and DONE are dropped
        @(negedge clk);
        push(1, 2'd1, 32'h30, 3);
        bus.req_cmd_in[1] = 4'd1; bus.req_data_in[1] = 32'h10;
        @(negedge clk);
        bus.req_cmd_in[1] = 4'd0; bus.req_data_in[1] = 32'h20;
        @(negedge clk);
        bus.req_cmd_in[1] = 4'd1; bus.req_data_in[1] = 32'h55;
        @(negedge clk);
        bus.req_cmd_in[1] = 4'd2; bus.req_data_in[1] = 32'h66;
        @(negedge clk);
        bus.req_cmd_in[1] = 4'd0; bus.req_data_in[1] = '0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("dropped_cmd_busy", 64'(bus.port_busy), 64'd0);

        // Reset pulse so the burst starts with the pointer at port 0
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // All ports add 1+1 on one edge: grants 0,1,2,3 back to back
        burst({4'd1, 4'd1, 4'd1, 4'd1}, {32'd1, 32'd1, 32'd1, 32'd1},
              {32'd1, 32'd1, 32'd1, 32'd1}, {2'd1, 2'd1, 2'd1, 2'd1},
              {32'd2, 32'd2, 32'd2, 32'd2}, {4'd6, 4'd5, 4'd4, 4'd3});
        @(negedge clk);
        @(negedge clk);
        chk("burst_busy_c4", 64'(bus.port_busy), 64'b1110);
        @(negedge clk);
        chk("burst_busy_c5", 64'(bus.port_busy), 64'b1100);
        wait_idle();

        // Repeat burst with mixed ops: pointer wrapped back to port 0
        burst({4'd1, 4'd5, 4'd2, 4'd1},
              {32'hFFFF_FFFF, 32'd3, 32'd9, 32'h1234},
              {32'd1, 32'd2, 32'd4, 32'h1},
              {2'd2, 2'd1, 2'd1, 2'd1},
              {32'd0, 32'd12, 32'd5, 32'h1235},
              {4'd6, 4'd5, 4'd4, 4'd3});
        wait_idle();

        // Last grant port 1 -> search starts at port 2: port 2 before port 0
        op(1, 4'd1, 32'd4, 32'd4, 2'd1, 32'd8);
        burst({4'd0, 4'd6, 4'd0, 4'd1}, {32'd0, 32'hF0, 32'd0, 32'd7},
              {32'd0, 32'd4, 32'd0, 32'd8}, {2'd0, 2'd1, 2'd0, 2'd1},
              {32'd0, 32'hF, 32'd0, 32'd15}, {4'd0, 4'd3, 4'd0, 4'd4});
        wait_idle();

        // Reset between operand2 edge and grant: immediate clear, no response
        @(negedge clk);
        bus.req_cmd_in[0] = 4'd1; bus.req_data_in[0] = 32'd7;
        @(negedge clk);
        bus.req_cmd_in[0] = 4'd0; bus.req_data_in[0] = 32'd9;
        @(negedge clk);
        bus.req_data_in[0] = '0;
        chk("pre_reset_busy", 64'(bus.port_busy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 64'(bus.port_busy), 64'd0);
        chk("async_reset_resp", 64'(bus.out_resp), 64'd0);
        chk("async_reset_data", 64'(bus.out_data), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        op(0, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
